multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle main control unit for the CPU datapath, successor to the single-cycle opcode decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and waits on a memory handshake. It drives every datapath mux, write enable and ALU-op line per state, and adds branch-on-zero resolution, load/store, jumps, illegal-opcode detection and a memory-ack timeout. It sits between the instruction register/ALU-zero flag and the shared-memory multi-cycle datapath.

## Interface
- ALU_OP_W, 3: width of alu_op_o; must be at least 3; codes are zero-extended.
- ACK_TIMEOUT, 16: maximum cycles spent waiting for mem_ack_i; 0 disables the timeout.
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  reset; asynchronous, active-low
- instr_op_i  in  6  opcode from the instruction register; valid from DECODE onward
- zero_i  in  1  ALU zero flag, sampled in EXEC
- mem_ack_i  in  1  memory completes the current request this cycle
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write (store)
- i_or_d_o  out  1  memory address select: 0=PC, 1=ALUOut
- ir_write_o  out  1  load the instruction register
- pc_write_o  out  1  PC write enable
- pc_src_o  out  2  PC source: 00=ALU, 01=ALUOut (branch target), 10=jump target
- alu_src_a_o  out  1  ALU A select: 0=PC, 1=rs
- alu_src_b_o  out  2  ALU B select: 00=rt, 01=4, 10=sign-extended imm, 11=imm<<2
- alu_op_o  out  ALU_OP_W  ALU operation: 000=ADD, 001=SUB, 010=R-funct, 011=SLTU, 100=OR, 101=LUI
- reg_dst_o  out  2  destination register: 00=rt, 01=rd, 10=$31
- mem_to_reg_o  out  2  write-back source: 00=ALUOut, 01=MDR, 10=PC
- reg_write_o  out  1  register file write
- illegal_o  out  1  one-cycle pulse on an unsupported opcode
- bus_err_o  out  1  one-cycle pulse on a memory-ack timeout
- state_o  out  3  current state, for debug

## Operation
- Supported opcodes: 0x00 R-type, 0x04 beq, 0x05 bne, 0x08 addi, 0x09 sltiu, 0x0d ori, 0x0f lui, 0x23 lw, 0x2b sw. With the jump feature compiled in: 0x02 j, 0x03 jal.
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- Outputs are a Moore function of state and the latched opcode op_q, plus ack/zero-qualified strobes.
- Any output not listed for a state is 0 in that state.
- FETCH:
  - Outputs: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_src=00.
  - On mem_ack_i: ir_write=1 and pc_write=1 in the same cycle, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Latch instr_op_i into op_q.
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=ADD (branch target computed into ALUOut).
  - Next: illegal opcode → illegal_o=1, go to FETCH; j → pc_write=1, pc_src=10, go to FETCH; jal → j outputs plus reg_write=1, reg_dst=10, mem_to_reg=10, go to FETCH; otherwise go to EXEC.
- EXEC: alu_src_a=1. By opcode:
  - R-type: alu_src_b=00, alu_op=R-funct.
  - addi/lw/sw: alu_src_b=10, alu_op=ADD.
  - sltiu: alu_src_b=10, alu_op=SLTU.
  - ori: alu_src_b=10, alu_op=OR.
  - lui: alu_src_b=10, alu_op=LUI.
  - beq/bne: alu_src_b=00, alu_op=SUB, pc_src=01; pc_write = (beq & zero_i) | (bne & ~zero_i); go to FETCH.
  - Next state: lw/sw → MEM; all others → WB.
- MEM:
  - Outputs: mem_req=1, i_or_d=1, mem_we=(op_q==sw).
  - On mem_ack_i: lw → WB; sw → FETCH.
- WB:
  - reg_write=1.
  - R-type: reg_dst=01, mem_to_reg=00; lw: reg_dst=00, mem_to_reg=01; I-arithmetic: reg_dst=00, mem_to_reg=00.
  - Go to FETCH.
- Timeout (ACK_TIMEOUT>0):
  - The wait counter clears on entry to FETCH or MEM and increments on each cycle without ack.
  - When the counter reaches ACK_TIMEOUT−1 and ack is still low: bus_err_o=1 and go to FETCH.
  - No ir_write, pc_write or reg_write is issued on a timeout.
  - If ack and the timeout fall in the same cycle, ack wins.

## Timing
- Reset: while rst_i is low, state=FETCH, op_q=0, counter=0, and every output (including state_o's downstream use) is forced to 0.
- The first mem_req_o appears in the first cycle after rst_i rises.
- Reset asserted mid-instruction aborts it immediately; no partial write completes.
- Cycle counts with zero-wait memory: branch/j/jal 3 or 2 cycles, R/I 4, sw 4, lw 5. Each wait cycle adds 1.
- mem_ack_i is accepted only while mem_req_o=1. Ack in any other state is ignored.

## Configuration
- MULTICYCLE_CTRL_JUMP_EN defined: j and jal decode as described above.
- Undefined: opcodes 0x02 and 0x03 raise illegal_o and return to FETCH; pc_src_o never equals 10; reg_dst_o and mem_to_reg_o never equal 10.

## Structure
- Package ctrl_pkg holds: opcode constants, state encodings, ALU-op codes, and the mux-select encodings for pc_src, alu_src_b, reg_dst and mem_to_reg.
- Sub-module ctrl_ack_timer: the wait counter, with inputs clear, ack and active, and a timeout pulse output; parametrised by ACK_TIMEOUT.

## Test plan
- Reset release, then addi with zero-wait memory → states 0,1,2,4,0; EXEC alu_op=000, alu_src_b=10; WB reg_write=1, reg_dst=00.
- lw, with mem_ack_i delayed 2 cycles in MEM → MEM held 3 cycles; WB has mem_to_reg=01.
- beq with zero_i=1 → pc_write=1, pc_src=01 in EXEC; bne with zero_i=1 → pc_write=0.
- Opcode 0x3f → illegal_o pulses once in DECODE, next state FETCH, no register writes.
- ACK_TIMEOUT=4 with mem_ack_i never asserted in FETCH → bus_err_o pulses in the 4th cycle, FETCH restarts. Repeat with ack arriving in the 4th cycle → no bus_err_o.
- jal with the macro defined → DECODE shows reg_write=1, reg_dst=10, pc_src=10. Without the macro → illegal_o pulses.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle main control unit: opcodes, state
// encodings, ALU-op codes, datapath mux selects and the internal control word.
package ctrl_pkg;

  localparam int unsigned OP_W       = 6;
  localparam int unsigned STATE_W    = 3;
  localparam int unsigned ALU_CODE_W = 3;

  // Opcodes recognised by the decoder
  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'h09;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0d;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0f;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2b;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  typedef enum logic [ALU_CODE_W-1:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_RFUNCT = 3'd2,
    ALU_SLTU   = 3'd3,
    ALU_OR     = 3'd4,
    ALU_LUI    = 3'd5
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_SRC_ALU    = 2'b00,
    PC_SRC_ALUOUT = 2'b01,
    PC_SRC_JUMP   = 2'b10
  } pc_src_e;

  typedef enum logic [1:0] {
    SRC_B_RT      = 2'b00,
    SRC_B_FOUR    = 2'b01,
    SRC_B_IMM     = 2'b10,
    SRC_B_IMM_SH2 = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    REG_DST_RT = 2'b00,
    REG_DST_RD = 2'b01,
    REG_DST_RA = 2'b10
  } reg_dst_e;

  typedef enum logic [1:0] {
    WB_SRC_ALUOUT = 2'b00,
    WB_SRC_MDR    = 2'b01,
    WB_SRC_PC     = 2'b10
  } mem_to_reg_e;

  // One cycle's worth of datapath control
  typedef struct packed {
    logic        mem_req;
    logic        mem_we;
    logic        i_or_d;
    logic        ir_write;
    logic        pc_write;
    pc_src_e     pc_src;
    logic        alu_src_a;
    alu_src_b_e  alu_src_b;
    alu_op_e     alu_op;
    reg_dst_e    reg_dst;
    mem_to_reg_e mem_to_reg;
    logic        reg_write;
    logic        illegal;
    logic        bus_err;
  } ctrl_word_t;

  // Opcode legality; j/jal only count when the jump feature is built in
  function automatic logic op_is_legal(input logic [OP_W-1:0] op, input logic jump_en);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTIU,
      OP_ORI, OP_LUI, OP_LW, OP_SW: legal = 1'b1;
      OP_J, OP_JAL:                 legal = jump_en;
      default:                      legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multi-cycle controller (master) and the datapath
// / memory side (slave).
interface multicycle_ctrl_if #(
  parameter int unsigned ALU_OP_W = 3
);
  import ctrl_pkg::*;

  logic [OP_W-1:0]     instr_op_i;
  logic                zero_i;
  logic                mem_ack_i;
  logic                mem_req_o;
  logic                mem_we_o;
  logic                i_or_d_o;
  logic                ir_write_o;
  logic                pc_write_o;
  logic [1:0]          pc_src_o;
  logic                alu_src_a_o;
  logic [1:0]          alu_src_b_o;
  logic [ALU_OP_W-1:0] alu_op_o;
  logic [1:0]          reg_dst_o;
  logic [1:0]          mem_to_reg_o;
  logic                reg_write_o;
  logic                illegal_o;
  logic                bus_err_o;
  logic [STATE_W-1:0]  state_o;

  modport master (
    input  instr_op_i, zero_i, mem_ack_i,
    output mem_req_o, mem_we_o, i_or_d_o, ir_write_o, pc_write_o, pc_src_o,
           alu_src_a_o, alu_src_b_o, alu_op_o, reg_dst_o, mem_to_reg_o,
           reg_write_o, illegal_o, bus_err_o, state_o
  );

  modport slave (
    output instr_op_i, zero_i, mem_ack_i,
    input  mem_req_o, mem_we_o, i_or_d_o, ir_write_o, pc_write_o, pc_src_o,
           alu_src_a_o, alu_src_b_o, alu_op_o, reg_dst_o, mem_to_reg_o,
           reg_write_o, illegal_o, bus_err_o, state_o
  );

endinterface

// File: rtl/multicycle_ctrl_ack_timer.sv
// Memory-ack wait counter: counts request cycles without ack and flags a
// timeout on the last allowed cycle. ACK_TIMEOUT=0 removes the counter.
module ctrl_ack_timer #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic ack,
  input  logic active,
  output logic timeout_c
);

  if (ACK_TIMEOUT > 0) begin : g_timer
    localparam int unsigned CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q;

    // Count unacknowledged request cycles; restart on clear
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        cnt_q <= '0;
      end else if (clear) begin
        cnt_q <= '0;
      end else if (active && !ack) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    // Ack in the final cycle still wins over the timeout
    assign timeout_c = active && !ack && (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
  end else begin : g_no_timer
    assign timeout_c = 1'b0;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// memory handshake, branch resolution, illegal-opcode and ack-timeout
// detection. Define MULTICYCLE_CTRL_JUMP_EN to decode j/jal.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned ALU_OP_W    = 3,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  multicycle_ctrl_if.master   bus
);

`ifdef MULTICYCLE_CTRL_JUMP_EN
  localparam logic JUMP_EN = 1'b1;
`else
  localparam logic JUMP_EN = 1'b0;
`endif

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q;
  ctrl_word_t      ctl, ctl_g;
  logic            mem_ack, zero, timeout_c, timer_clear, timer_active;
  logic [OP_W-1:0] instr_op;

  assign mem_ack  = bus.mem_ack_i;
  assign zero     = bus.zero_i;
  assign instr_op = bus.instr_op_i;

  // State register and opcode latch (captured in DECODE)
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) op_q <= instr_op;
    end
  end

  // Next state and per-state datapath control
  always_comb begin
    state_d = state_q;
    ctl     = '0;
    case (state_q)
      ST_FETCH: begin
        ctl.mem_req   = 1'b1;
        ctl.alu_src_b = SRC_B_FOUR;
        ctl.alu_op    = ALU_ADD;
        ctl.pc_src    = PC_SRC_ALU;
        if (mem_ack) begin
          ctl.ir_write = 1'b1;
          ctl.pc_write = 1'b1;
          state_d      = ST_DECODE;
        end else if (timeout_c) begin
          ctl.bus_err = 1'b1;
          state_d     = ST_FETCH;
        end
      end
      ST_DECODE: begin
        ctl.alu_src_b = SRC_B_IMM_SH2;
        ctl.alu_op    = ALU_ADD;
        if (!op_is_legal(instr_op, JUMP_EN)) begin
          ctl.illegal = 1'b1;
          state_d     = ST_FETCH;
        end else if (JUMP_EN && (instr_op == OP_J || instr_op == OP_JAL)) begin
          ctl.pc_write = 1'b1;
          ctl.pc_src   = PC_SRC_JUMP;
          if (instr_op == OP_JAL) begin
            ctl.reg_write  = 1'b1;
            ctl.reg_dst    = REG_DST_RA;
            ctl.mem_to_reg = WB_SRC_PC;
          end
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        ctl.alu_src_a = 1'b1;
        state_d       = ST_WB;
        case (op_q)
          OP_RTYPE: begin
            ctl.alu_src_b = SRC_B_RT;
            ctl.alu_op    = ALU_RFUNCT;
          end
          OP_ADDI: begin
            ctl.alu_src_b = SRC_B_IMM;
            ctl.alu_op    = ALU_ADD;
          end
          OP_LW, OP_SW: begin
            ctl.alu_src_b = SRC_B_IMM;
            ctl.alu_op    = ALU_ADD;
            state_d       = ST_MEM;
          end
          OP_SLTIU: begin
            ctl.alu_src_b = SRC_B_IMM;
            ctl.alu_op    = ALU_SLTU;
          end
          OP_ORI: begin
            ctl.alu_src_b = SRC_B_IMM;
            ctl.alu_op    = ALU_OR;
          end
          OP_LUI: begin
            ctl.alu_src_b = SRC_B_IMM;
            ctl.alu_op    = ALU_LUI;
          end
          OP_BEQ, OP_BNE: begin
            ctl.alu_src_b = SRC_B_RT;
            ctl.alu_op    = ALU_SUB;
            ctl.pc_src    = PC_SRC_ALUOUT;
            ctl.pc_write  = ((op_q == OP_BEQ) && zero) || ((op_q == OP_BNE) && !zero);
            state_d       = ST_FETCH;
          end
          default: state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        ctl.mem_req = 1'b1;
        ctl.i_or_d  = 1'b1;
        ctl.mem_we  = (op_q == OP_SW);
        if (mem_ack) begin
          state_d = (op_q == OP_LW) ? ST_WB : ST_FETCH;
        end else if (timeout_c) begin
          ctl.bus_err = 1'b1;
          state_d     = ST_FETCH;
        end
      end
      ST_WB: begin
        ctl.reg_write = 1'b1;
        if (op_q == OP_RTYPE) begin
          ctl.reg_dst = REG_DST_RD;
        end else if (op_q == OP_LW) begin
          ctl.mem_to_reg = WB_SRC_MDR;
        end
        state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Restart the wait count whenever a request phase is (re)entered
  assign timer_active = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign timer_clear  = (state_d != state_q) || timeout_c;

  ctrl_ack_timer #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_ack_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear     (timer_clear),
    .ack       (mem_ack),
    .active    (timer_active),
    .timeout_c (timeout_c)
  );

  // Reset forces every control line low, including ack-qualified strobes
  assign ctl_g = rst_i ? ctl : '0;

  assign bus.mem_req_o    = ctl_g.mem_req;
  assign bus.mem_we_o     = ctl_g.mem_we;
  assign bus.i_or_d_o     = ctl_g.i_or_d;
  assign bus.ir_write_o   = ctl_g.ir_write;
  assign bus.pc_write_o   = ctl_g.pc_write;
  assign bus.pc_src_o     = ctl_g.pc_src;
  assign bus.alu_src_a_o  = ctl_g.alu_src_a;
  assign bus.alu_src_b_o  = ctl_g.alu_src_b;
  assign bus.alu_op_o     = ALU_OP_W'(ctl_g.alu_op);
  assign bus.reg_dst_o    = ctl_g.reg_dst;
  assign bus.mem_to_reg_o = ctl_g.mem_to_reg;
  assign bus.reg_write_o  = ctl_g.reg_write;
  assign bus.illegal_o    = ctl_g.illegal;
  assign bus.bus_err_o    = ctl_g.bus_err;
  assign bus.state_o      = rst_i ? STATE_W'(state_q) : STATE_W'(0);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: an instruction-level model expands each
// instruction into its expected per-cycle control trace, which is replayed
// against the DUT; literal checks pin key cycles of the observed traces.
module tb_multicycle_ctrl;

  localparam int unsigned T = 4;
`ifdef MULTICYCLE_CTRL_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] st;
    logic       mem_req, mem_we, i_or_d, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       a;
    logic [1:0] b;
    logic [2:0] alu;
    logic [1:0] rd, m2r;
    logic       rw, ill, berr;
  } obs_t;

  typedef struct packed {
    logic       ack, zero;
    logic [5:0] op;
    obs_t       o;
  } cyc_t;

  logic clk = 1'b0;
  logic rst_i = 1'b0;
  int   checks = 0;
  int   fails = 0;
  cyc_t exp_q[$];
  obs_t trace[$];

  multicycle_ctrl_if #(.ALU_OP_W(3)) bus ();

  multicycle_ctrl #(.ALU_OP_W(3), .ACK_TIMEOUT(T)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  function automatic obs_t sample();
    obs_t s;
    s.st = bus.state_o;        s.mem_req = bus.mem_req_o;  s.mem_we = bus.mem_we_o;
    s.i_or_d = bus.i_or_d_o;   s.ir_write = bus.ir_write_o; s.pc_write = bus.pc_write_o;
    s.pc_src = bus.pc_src_o;   s.a = bus.alu_src_a_o;      s.b = bus.alu_src_b_o;
    s.alu = bus.alu_op_o;      s.rd = bus.reg_dst_o;       s.m2r = bus.mem_to_reg_o;
    s.rw = bus.reg_write_o;    s.ill = bus.illegal_o;      s.berr = bus.bus_err_o;
    return s;
  endfunction

  function automatic bit legal(input logic [5:0] op);
    case (op)
      6'h00, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0d, 6'h0f, 6'h23, 6'h2b: return 1'b1;
      6'h02, 6'h03: return JUMP_EN;
      default: return 1'b0;
    endcase
  endfunction

  function automatic cyc_t blank(input logic [5:0] op, input logic zero, input logic ack);
    cyc_t c;
    c = '0;
    c.op = op; c.zero = zero; c.ack = ack;
    return c;
  endfunction

  // Request phase: wait cycles (with timeouts every T idle cycles) then the ack
  // cycle. Returns 0 if the phase ended in a timeout with no ack.
  function automatic bit req_phase(input cyc_t base, input int waits, input bit retry);
    cyc_t c;
    int w;
    w = waits;
    while (T > 0 && w >= T) begin
      for (int i = 0; i < T; i++) begin
        c = base; c.o.berr = (i == T - 1);
        exp_q.push_back(c);
      end
      w -= T;
      if (!retry) return 1'b0;
      base.o.st = 3'd0; // timeout always lands in FETCH
    end
    for (int i = 0; i < w; i++) exp_q.push_back(base);
    return 1'b1;
  endfunction

  // Expand one instruction into its expected cycle trace
  task automatic model_instr(input logic [5:0] op, input logic zero, input int fw,
                             input int mw, input bit noisy);
    cyc_t c;
    c = blank(op, zero, 1'b0);
    c.o.mem_req = 1'b1; c.o.b = 2'b01;
    void'(req_phase(c, fw, 1'b1));
    c.ack = 1'b1; c.o.ir_write = 1'b1; c.o.pc_write = 1'b1;
    exp_q.push_back(c);
    c = blank(op, zero, noisy);
    c.o.st = 3'd1; c.o.b = 2'b11;
    if (!legal(op)) begin
      c.o.ill = 1'b1; exp_q.push_back(c); return;
    end
    if (op == 6'h02 || op == 6'h03) begin
      c.o.pc_write = 1'b1; c.o.pc_src = 2'b10;
      if (op == 6'h03) begin c.o.rw = 1'b1; c.o.rd = 2'b10; c.o.m2r = 2'b10; end
      exp_q.push_back(c); return;
    end
    exp_q.push_back(c);
    c = blank(op, zero, noisy);
    c.o.st = 3'd2; c.o.a = 1'b1; c.o.b = 2'b10;
    case (op)
      6'h00: begin c.o.b = 2'b00; c.o.alu = 3'd2; end
      6'h09: c.o.alu = 3'd3;
      6'h0d: c.o.alu = 3'd4;
      6'h0f: c.o.alu = 3'd5;
      6'h04, 6'h05: begin
        c.o.b = 2'b00; c.o.alu = 3'd1; c.o.pc_src = 2'b01;
        c.o.pc_write = (op == 6'h04) ? zero : !zero;
        exp_q.push_back(c); return;
      end
      default: c.o.alu = 3'd0;
    endcase
    exp_q.push_back(c);
    if (op == 6'h23 || op == 6'h2b) begin
      c = blank(op, zero, 1'b0);
      c.o.st = 3'd3; c.o.mem_req = 1'b1; c.o.i_or_d = 1'b1; c.o.mem_we = (op == 6'h2b);
      if (!req_phase(c, mw, 1'b0)) return;
      c.ack = 1'b1;
      exp_q.push_back(c);
      if (op == 6'h2b) return;
    end
    c = blank(op, zero, noisy);
    c.o.st = 3'd4; c.o.rw = 1'b1;
    if (op == 6'h00) c.o.rd = 2'b01;
    if (op == 6'h23) c.o.m2r = 2'b01;
    exp_q.push_back(c);
  endtask

  // Replay queued cycles: drive at the falling edge, check 1ns later
  task automatic run_queue(input string name, input int limit);
    cyc_t c;
    obs_t got;
    int   n;
    n = 0;
    trace.delete();
    while (exp_q.size() > 0 && n < limit) begin
      c = exp_q.pop_front();
      bus.instr_op_i = c.op; bus.zero_i = c.zero; bus.mem_ack_i = c.ack;
      #1;
      got = sample();
      trace.push_back(got);
      checks++;
      if (got !== c.o) begin
        fails++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, n, got, c.o);
      end
      n++;
      @(negedge clk);
    end
    exp_q.delete();
  endtask

  task automatic run_instr(input string name, input logic [5:0] op, input logic zero,
                           input int fw, input int mw, input bit noisy);
    model_instr(op, zero, fw, mw, noisy);
    run_queue(name, 1000);
  endtask

  task automatic check_int(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  function automatic int count_st(input logic [2:0] s);
    int n;
    n = 0;
    foreach (trace[i]) if (trace[i].st == s) n++;
    return n;
  endfunction

  function automatic int count_berr();
    int n;
    n = 0;
    foreach (trace[i]) n += int'(trace[i].berr);
    return n;
  endfunction

  initial begin
    bus.instr_op_i = 6'h08; bus.zero_i = 1'b0; bus.mem_ack_i = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_int("reset outputs", int'(sample()), 0);
    @(negedge clk);
    rst_i = 1'b1;

    run_instr("addi", 6'h08, 1'b0, 0, 0, 1'b0);
    check_int("addi cycles", trace.size(), 4);
    check_int("addi st0", int'(trace[0].st), 0);
    check_int("addi st1", int'(trace[1].st), 1);
    check_int("addi st2", int'(trace[2].st), 2);
    check_int("addi st3", int'(trace[3].st), 4);
    check_int("addi exec b", int'(trace[2].b), 2);
    check_int("addi wb rw", int'(trace[3].rw), 1);

    run_instr("lw", 6'h23, 1'b0, 0, 2, 1'b0);
    check_int("lw mem cycles", count_st(3'd3), 3);
    check_int("lw wb m2r", int'(trace[trace.size()-1].m2r), 1);

    run_instr("beq taken", 6'h04, 1'b1, 0, 0, 1'b0);
    check_int("beq pc_write", int'(trace[2].pc_write), 1);
    check_int("beq pc_src", int'(trace[2].pc_src), 1);
    run_instr("bne zero", 6'h05, 1'b1, 0, 0, 1'b0);
    check_int("bne pc_write", int'(trace[2].pc_write), 0);
    run_instr("beq not", 6'h04, 1'b0, 1, 0, 1'b1);
    run_instr("bne taken", 6'h05, 1'b0, 0, 0, 1'b0);

    run_instr("illegal", 6'h3f, 1'b0, 0, 0, 1'b1);
    check_int("illegal cycles", trace.size(), 2);
    check_int("illegal pulse", int'(trace[1].ill), 1);
    check_int("illegal rw", int'(trace[0].rw) + int'(trace[1].rw), 0);

    run_instr("fetch timeout", 6'h08, 1'b0, 4, 0, 1'b0);
    check_int("timeout berr cycle4", int'(trace[3].berr), 1);
    check_int("timeout restart", int'(trace[4].st), 0);
    check_int("timeout no ir_write", int'(trace[3].ir_write), 0);
    check_int("timeout berr count", count_berr(), 1);
    run_instr("ack in 4th", 6'h08, 1'b0, 3, 0, 1'b0);
    check_int("late ack berr", count_berr(), 0);
    run_instr("ack in 4th again", 6'h0d, 1'b0, 3, 0, 1'b0);
    check_int("counter cleared", count_berr(), 0);

    run_instr("jal", 6'h03, 1'b0, 0, 0, 1'b0);
    if (JUMP_EN) begin
      check_int("jal rw", int'(trace[1].rw), 1);
      check_int("jal rd", int'(trace[1].rd), 2);
      check_int("jal pc_src", int'(trace[1].pc_src), 2);
    end else begin
      check_int("jal illegal", int'(trace[1].ill), 1);
      check_int("jal pc_src", int'(trace[1].pc_src), 0);
    end
    run_instr("j", 6'h02, 1'b0, 1, 0, 1'b1);

    run_instr("rtype", 6'h00, 1'b0, 0, 0, 1'b1);
    check_int("rtype wb rd", int'(trace[3].rd), 1);
    run_instr("sltiu", 6'h09, 1'b1, 2, 0, 1'b1);
    run_instr("lui", 6'h0f, 1'b0, 0, 0, 1'b0);
    run_instr("sw", 6'h2b, 1'b0, 0, 1, 1'b1);
    check_int("sw cycles", trace.size(), 5);
    run_instr("sw timeout", 6'h2b, 1'b0, 2, 4, 1'b0);
    check_int("sw timeout berr", int'(trace[trace.size()-1].berr), 1);
    run_instr("lw slow", 6'h23, 1'b0, 1, 3, 1'b1);
    check_int("lw slow berr", count_berr(), 0);
    run_instr("illegal 10", 6'h10, 1'b0, 0, 0, 1'b0);

    // Reset in WB must suppress the register write at once
    model_instr(6'h08, 1'b0, 0, 0, 1'b0);
    run_queue("abort", 3);
    bus.mem_ack_i = 1'b1;
    rst_i = 1'b0;
    #1;
    check_int("abort outputs", int'(sample()), 0);
    @(negedge clk);
    #1;
    check_int("abort state", int'(bus.state_o), 0);
    @(negedge clk);
    rst_i = 1'b1;
    run_instr("after abort", 6'h0d, 1'b0, 0, 0, 1'b0);
    check_int("after abort cycles", trace.size(), 4);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
